// File: rtl/cpu_core_if.sv
// Debug port of cpu_core: the host side writes instruction words into the core's
// instruction memory.
interface cpu_core_if #(
    parameter int XLEN = 32
);
    logic            dbg_wr_en;
    logic [XLEN-1:0] dbg_addr;
    logic [XLEN-1:0] dbg_instr;

    modport master (output dbg_wr_en, output dbg_addr, output dbg_instr);
    modport slave  (input  dbg_wr_en, input  dbg_addr, input  dbg_instr);
endinterface

// File: rtl/cpu_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute from local imem/dmem,
// with every state update on the rising clock edge.
module cpu_core #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    cpu_core_if.slave dbg
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] regfile [0:31];
    logic [XLEN-1:0] imem    [0:255];
    logic [XLEN-1:0] dmem    [0:255];

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2, shamt;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] alu_b, alu_y, pc_plus4, next_pc, rd_data;
    logic [XLEN-1:0] mem_addr, load_word, store_data;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [3:0]      store_be;
    logic            rd_we, branch_taken;
    logic            unused_bits;

    assign instr  = imem[pc[9:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];

    assign rs1_val = (rs1 == 5'd0) ? '0 : regfile[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regfile[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc + 32'd4;
    assign alu_b    = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt    = alu_b[4:0];

    // instr[30] selects SUB only for register ops; for shifts it selects arithmetic
    always_comb begin
        case (funct3)
            3'b000:  alu_y = (opcode == OP_REG && alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_y = rs1_val << shamt;
            3'b010:  alu_y = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_y = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
            3'b100:  alu_y = rs1_val ^ alu_b;
            3'b101:  alu_y = alt ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    assign mem_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign load_word = dmem[mem_addr[9:2]];
    assign load_byte = load_word[{mem_addr[1:0], 3'b000} +: 8];
    assign load_half = mem_addr[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        store_be   = 4'b0000;
        store_data = rs2_val;
        case (funct3)
            3'b000: begin
                store_be   = 4'b0001 << mem_addr[1:0];
                store_data = {4{rs2_val[7:0]}};
            end
            3'b001: begin
                store_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{rs2_val[15:0]}};
            end
            3'b010:  store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
        if (opcode != OP_STORE) store_be = 4'b0000;
    end

    always_comb begin
        rd_we   = 1'b0;
        rd_data = alu_y;
        next_pc = pc_plus4;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_data = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_data = pc + imm_u; end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = rs1_val + imm_i;
            end
            OP_BRANCH: if (branch_taken) next_pc = pc + imm_b;
            OP_LOAD: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_data = {{24{load_byte[7]}}, load_byte};
                    3'b001:  rd_data = {{16{load_half[15]}}, load_half};
                    3'b010:  rd_data = load_word;
                    3'b100:  rd_data = {24'b0, load_byte};
                    3'b101:  rd_data = {16'b0, load_half};
                    default: rd_we = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: rd_we = 1'b1;
            default: ;
        endcase
        // pc stays word aligned; this also covers the JALR bit-0 clear
        next_pc[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (dbg.dbg_wr_en) imem[dbg.dbg_addr[9:2]] <= dbg.dbg_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be[i]) dmem[mem_addr[9:2]][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) regfile[rd] <= rd_data;
        end
    end

    assign unused_bits = ^{dbg.dbg_addr[XLEN-1:10], dbg.dbg_addr[1:0], mem_addr[XLEN-1:10]};
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs with fixed expectations, plus random programs
// compared against an instruction-level reference model with a byte-addressed data memory.
module tb_cpu_core;
    logic clk = 1'b0;
    logic rst;

    cpu_core_if #(.XLEN(32)) dbg_bus ();
    cpu_core #(.XLEN(32)) dut (.clk(clk), .rst(rst), .dbg(dbg_bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_reg  [32];
    logic [31:0] m_imem [256];
    logic [7:0]  m_dmem [1024];
    logic [31:0] prog_buf [256];

    typedef struct packed {
        logic [7:0][31:0] prog;
        logic [3:0]       len;
        logic [3:0]       cycles;
        logic [2:0][4:0]  chk_reg;
        logic [2:0][31:0] chk_val;
        logic [31:0]      exp_pc;
    } vec_t;

    vec_t  vecs [4];
    string vec_name [4] = '{"alu", "mem", "branch_x0", "jalr_lui"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[11:5], 5'(rs2), 5'(rs1), 3'(f3), iv[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[12], iv[10:5], 5'(rs2), 5'(rs1), 3'(f3), iv[4:1], iv[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] iv;
        iv = 32'(imm);
        return {iv[20], iv[10:1], iv[11], iv[19:12], 5'(rd), 7'h6F};
    endfunction

    // Reference model: immediates recovered by arithmetic shifts of the whole word
    function automatic logic [31:0] dec_i(logic [31:0] w);
        return 32'($signed(w) >>> 20);
    endfunction
    function automatic logic [31:0] dec_s(logic [31:0] w);
        return (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
    endfunction
    function automatic logic [31:0] dec_b(logic [31:0] w);
        return (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
             | (32'(w[11:8]) << 1);
    endfunction
    function automatic logic [31:0] dec_j(logic [31:0] w);
        return (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
             | (32'(w[30:21]) << 1);
    endfunction

    function automatic bit cond_true(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] arith(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                          bit negate, bit sign_fill);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return negate ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return sign_fill ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] model_word(int idx);
        return {m_dmem[4*idx+3], m_dmem[4*idx+2], m_dmem[4*idx+1], m_dmem[4*idx]};
    endfunction

    task automatic model_step();
        logic [31:0] w, a, b, nxt, res, addr;
        logic [15:0] h;
        logic [2:0]  f3;
        int          rd;
        bit          wr;
        w   = m_imem[(m_pc / 4) % 256];
        f3  = w[14:12];
        rd  = int'(w[11:7]);
        a   = m_reg[w[19:15]];
        b   = m_reg[w[24:20]];
        nxt = m_pc + 4;
        res = 0;
        wr  = 0;
        case (w[6:0])
            7'h37: begin wr = 1; res = w & 32'hFFFFF000; end
            7'h17: begin wr = 1; res = m_pc + (w & 32'hFFFFF000); end
            7'h6F: begin wr = 1; res = m_pc + 4; nxt = m_pc + dec_j(w); end
            7'h67: begin wr = 1; res = m_pc + 4; nxt = (a + dec_i(w)) & ~32'd1; end
            7'h63: if (cond_true(f3, a, b)) nxt = m_pc + dec_b(w);
            7'h03: begin
                addr = (a + dec_i(w)) % 1024;
                wr = 1;
                case (f3)
                    3'd0: res = 32'($signed(m_dmem[addr]));
                    3'd4: res = 32'(m_dmem[addr]);
                    3'd1, 3'd5: begin
                        h   = {m_dmem[(addr & ~32'd1) + 1], m_dmem[addr & ~32'd1]};
                        res = (f3 == 3'd1) ? 32'($signed(h)) : 32'(h);
                    end
                    3'd2: res = model_word(int'(addr / 4));
                    default: wr = 0;
                endcase
            end
            7'h23: begin
                addr = (a + dec_s(w)) % 1024;
                case (f3)
                    3'd0: m_dmem[addr] = b[7:0];
                    3'd1: for (int k = 0; k < 2; k++) m_dmem[(addr & ~32'd1) + k] = b[8*k +: 8];
                    3'd2: for (int k = 0; k < 4; k++) m_dmem[(addr & ~32'd3) + k] = b[8*k +: 8];
                    default: ;
                endcase
            end
            7'h13: begin wr = 1; res = arith(f3, a, dec_i(w), 0, w[30]); end
            7'h33: begin wr = 1; res = arith(f3, a, b, w[30], w[30]); end
            default: ;
        endcase
        if (wr && rd != 0) m_reg[rd] = res;
        m_pc = nxt & ~32'd3;
    endtask

    task automatic tick();
        if (rst) begin
            m_pc = 0;
            for (int k = 0; k < 32; k++) m_reg[k] = 0;
        end else begin
            model_step();
        end
        if (dbg_bus.dbg_wr_en) m_imem[dbg_bus.dbg_addr[9:2]] = dbg_bus.dbg_instr;
        @(posedge clk);
        #1;
    endtask

    // Rewrites all of imem from prog_buf under reset and leaves the core ready at pc 0
    task automatic load_program();
        rst = 1'b1;
        dbg_bus.dbg_wr_en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            dbg_bus.dbg_addr  = 32'(k * 4);
            dbg_bus.dbg_instr = prog_buf[k];
            tick();
        end
        dbg_bus.dbg_wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rd, rs1, rs2, f3, imm;
        k   = $urandom_range(0, 10);
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        f3  = $urandom_range(0, 7);
        imm = $urandom_range(0, 4095);
        case (k)
            0, 1: begin
                if (f3 == 1) imm = imm % 32;
                if (f3 == 5) imm = (imm % 32) + ($urandom_range(0, 1) == 1 ? 1024 : 0);
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            2, 3: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                               rs2, rs1, f3, rd);
            4: return enc_u($urandom_range(0, 20'hFFFFF), rd, 7'h37);
            5: return enc_u($urandom_range(0, 20'hFFFFF), rd, 7'h17);
            6: begin
                f3 = $urandom_range(0, 4);
                if (f3 > 2) f3 = f3 + 1;
                return enc_i(imm, rs1, f3, rd, 7'h03);
            end
            7: return enc_s(imm, rs2, rs1, $urandom_range(0, 2));
            8: begin
                f3 = $urandom_range(0, 5);
                if (f3 > 1) f3 = f3 + 2;
                return enc_b(4 * $urandom_range(1, 4), rs2, rs1, f3);
            end
            9: return enc_j(4 * $urandom_range(1, 3), rd);
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'h0;
                    1: return {$urandom_range(0, 32'h1FFFFFF) & 32'h1FFFFFF, 7'h0F} & 32'hFFFFFFFF;
                    default: return enc_i(4 * $urandom_range(0, 30), 0, 0, rd, 7'h67);
                endcase
            end
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        dbg_bus.dbg_wr_en = 1'b0;
        dbg_bus.dbg_addr  = '0;
        dbg_bus.dbg_instr = '0;
        for (int k = 0; k < 256; k++) m_imem[k] = 0;
        for (int k = 0; k < 1024; k++) m_dmem[k] = 0;
        for (int k = 0; k < 32; k++) m_reg[k] = 0;
        m_pc = 0;

        vecs[0] = '0;
        vecs[0].prog[0] = enc_i(-5, 0, 0, 1, 7'h13);
        vecs[0].prog[1] = enc_i(3, 0, 0, 2, 7'h13);
        vecs[0].prog[2] = enc_r(32, 2, 1, 0, 3);
        vecs[0].prog[3] = enc_r(0, 2, 1, 3, 4);
        vecs[0].prog[4] = enc_i(12'h401, 1, 5, 5, 7'h13);
        vecs[0].len = 5; vecs[0].cycles = 5; vecs[0].exp_pc = 32'd20;
        vecs[0].chk_reg = {5'd5, 5'd4, 5'd3};
        vecs[0].chk_val = {32'hFFFFFFFD, 32'h0, 32'hFFFFFFF8};

        vecs[1] = '0;
        vecs[1].prog[0] = enc_i(12'h1FF, 0, 0, 1, 7'h13);
        vecs[1].prog[1] = enc_s(8, 1, 0, 2);
        vecs[1].prog[2] = enc_s(9, 0, 0, 0);
        vecs[1].prog[3] = enc_i(8, 0, 2, 2, 7'h03);
        vecs[1].prog[4] = enc_i(8, 0, 0, 3, 7'h03);
        vecs[1].prog[5] = enc_i(8, 0, 5, 4, 7'h03);
        vecs[1].len = 6; vecs[1].cycles = 6; vecs[1].exp_pc = 32'd24;
        vecs[1].chk_reg = {5'd4, 5'd3, 5'd2};
        vecs[1].chk_val = {32'h000000FF, 32'hFFFFFFFF, 32'h000000FF};

        vecs[2] = '0;
        vecs[2].prog[0] = enc_i(7, 0, 0, 0, 7'h13);
        vecs[2].prog[1] = enc_b(8, 0, 0, 0);
        vecs[2].prog[2] = enc_i(1, 0, 0, 6, 7'h13);
        vecs[2].prog[3] = enc_i(2, 0, 0, 7, 7'h13);
        vecs[2].len = 4; vecs[2].cycles = 3; vecs[2].exp_pc = 32'd16;
        vecs[2].chk_reg = {5'd7, 5'd6, 5'd0};
        vecs[2].chk_val = {32'd2, 32'd0, 32'd0};

        vecs[3] = '0;
        vecs[3].prog[0] = enc_u(20'h12345, 1, 7'h37);
        vecs[3].prog[1] = enc_u(0, 2, 7'h17);
        vecs[3].prog[2] = enc_i(13, 0, 0, 3, 7'h67);
        vecs[3].len = 3; vecs[3].cycles = 3; vecs[3].exp_pc = 32'd12;
        vecs[3].chk_reg = {5'd3, 5'd2, 5'd1};
        vecs[3].chk_val = {32'd12, 32'd4, 32'h12345000};

        // JAL loaded through the debug port into otherwise all-zero imem
        dbg_bus.dbg_wr_en = 1'b1;
        dbg_bus.dbg_addr  = 32'd4;
        dbg_bus.dbg_instr = 32'h0180016F;
        tick();
        dbg_bus.dbg_wr_en = 1'b0;
        check("reset_pc", dut.pc, 32'd0);
        check("reset_x2", dut.regfile[2], 32'd0);
        check("dbg_imem1", dut.imem[1], 32'h0180016F);
        rst = 1'b0;
        tick();
        check("jal_nop_pc", dut.pc, 32'd4);
        tick();
        check("jal_pc", dut.pc, 32'd28);
        check("jal_x2", dut.regfile[2], 32'd8);

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 256; k++) prog_buf[k] = (k < int'(vecs[t].len)) ? vecs[t].prog[k] : 32'h0;
            load_program();
            for (int c = 0; c < int'(vecs[t].cycles); c++) tick();
            for (int r = 0; r < 3; r++)
                check($sformatf("%s_x%0d", vec_name[t], vecs[t].chk_reg[r]),
                      dut.regfile[vecs[t].chk_reg[r]], vecs[t].chk_val[r]);
            check({vec_name[t], "_pc"}, dut.pc, vecs[t].exp_pc);
        end

        // Debug write to the word being fetched: old word executes, new one later
        for (int k = 0; k < 256; k++) prog_buf[k] = 0;
        prog_buf[0] = enc_i(1, 0, 0, 1, 7'h13);
        prog_buf[1] = enc_j(-4, 0);
        load_program();
        dbg_bus.dbg_wr_en = 1'b1;
        dbg_bus.dbg_addr  = 32'd0;
        dbg_bus.dbg_instr = enc_i(2, 0, 0, 1, 7'h13);
        tick();
        dbg_bus.dbg_wr_en = 1'b0;
        check("dbg_race_old_x1", dut.regfile[1], 32'd1);
        tick();
        check("dbg_race_loop_pc", dut.pc, 32'd0);
        tick();
        check("dbg_race_new_x1", dut.regfile[1], 32'd2);

        // Reset in the middle of a run keeps dmem
        for (int k = 0; k < 256; k++) prog_buf[k] = 0;
        prog_buf[0] = enc_i(5, 0, 0, 1, 7'h13);
        prog_buf[1] = enc_s(16, 1, 0, 2);
        prog_buf[2] = enc_i(9, 0, 0, 2, 7'h13);
        prog_buf[3] = enc_i(1, 0, 0, 3, 7'h13);
        load_program();
        for (int c = 0; c < 3; c++) tick();
        check("midrst_pre_pc", dut.pc, 32'd12);
        check("midrst_pre_x2", dut.regfile[2], 32'd9);
        check("midrst_pre_dmem", dut.dmem[4], 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pc", dut.pc, 32'd0);
        for (int r = 0; r < 32; r++) check($sformatf("midrst_x%0d", r), dut.regfile[r], 32'd0);
        check("midrst_dmem", dut.dmem[4], 32'd5);
        tick();
        check("midrst_restart_pc", dut.pc, 32'd4);
        check("midrst_restart_x1", dut.regfile[1], 32'd5);

        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 256; k++) prog_buf[k] = (k < 24) ? rand_instr() : 32'h0;
            load_program();
            for (int c = 0; c < 40; c++) tick();
            for (int r = 0; r < 32; r++) check($sformatf("rand%0d_x%0d", p, r), dut.regfile[r], m_reg[r]);
            check($sformatf("rand%0d_pc", p), dut.pc, m_pc);
            for (int k = 0; k < 256; k++) begin
                v = model_word(k);
                check($sformatf("rand%0d_dmem%0d", p, k), dut.dmem[k], v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_core.md
# cpu_core

Single-cycle RV32I integer core with separate instruction and data memories and a debug port for loading instruction memory. It is the top of the processor datapath: the bench writes a program through the debug port while reset is held, then releases reset and the core executes. There are no functional outputs. Verification observes state through the internal names `pc`, `regfile[0:31]`, `imem[0:255]` and `dmem[0:255]`.

## Interface
- XLEN, 32, datapath, register and address width; only 32 is supported.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dbg_wr_en  input  1  when high at a rising edge, writes dbg_instr into instruction memory.
- dbg_addr  input  XLEN  byte address of the debug write; word index is dbg_addr[9:2], and bits [1:0] and [31:10] are ignored.
- dbg_instr  input  XLEN  instruction word to write.

## Operation
- Memories: imem and dmem each hold 256 × 32-bit words (1 KiB), byte-addressed and little-endian.
  - Both are zero at time 0.
  - Neither is cleared by rst.
  - Addresses wrap modulo 1 KiB.
- Debug writes are accepted in any state, including during rst.
- Register file: 32 × 32-bit.
  - x0 always reads 0; writes to x0 are discarded.
  - Two combinational read ports and one write port; the write happens at the rising edge.
- Fetch: instr = imem[pc[9:2]], read combinationally. pc[1:0] is always 0.
- Supported opcodes:
  - LUI, AUIPC, JAL, JALR (target & ~1).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Immediates follow the standard I/S/B/U/J encodings and are sign-extended to 32 bits. Branch and jump offsets are relative to the current pc.
- Link value for JAL/JALR is pc+4.
- Any other opcode, including the all-zero word, executes as a NOP: no register or memory write, pc+4.
- Loads:
  - Sub-word lane is selected by addr[1:0] for byte and addr[1] for halfword.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned word/halfword accesses are not trapped; the low address bits are dropped.
- Stores: byte-enable write of the selected lanes of dmem[addr[9:2]], with the same lane rules as loads.
- Shift amounts use the low 5 bits. Arithmetic is modulo 2^32 with no overflow detection.

## Timing
- While rst is high at a rising edge:
  - pc ← 0 and every register ← 0.
  - No register or dmem write from execution.
  - Debug writes still occur.
- When rst is low at a rising edge, the instruction at pc completes in that cycle:
  - rd written, dmem written (stores), pc ← next pc.
  - CPI = 1; there is no pipeline and no stall.
- Loads: combinational dmem read, result written to rd at the same edge.
- Debug write and fetch of the same word in the same cycle: the executing instruction is the old content; the new word is visible from the next cycle.
- Reset asserted mid-program: at the next edge pc and registers return to 0; memories are kept.

## Test plan
- JAL via debug port:
  - Stimulus: write 0x0180016F at addr 4 with rst high, then release rst.
  - Required: cycle 1 executes the zero word at 0 as a NOP (pc=4); cycle 2 sets x2=8 and pc=28.
- ALU:
  - Program: ADDI x1,x0,-5; ADDI x2,x0,3; SUB x3,x1,x2; SLTU x4,x1,x2; SRAI x5,x1,1.
  - Required: x3=0xFFFFFFF8, x4=0, x5=0xFFFFFFFD.
- Memory:
  - Program: ADDI x1,x0,0x1FF; SW x1,8(x0); SB x0,9(x0); LW x2,8(x0); LB x3,8(x0); LHU x4,8(x0).
  - Required: x2=0x000000FF, x3=0xFFFFFFFF, x4=0x00FF.
- Branch/x0:
  - Program: ADDI x0,x0,7; BEQ x0,x0,+8; skipped ADDI x6,x0,1; target ADDI x7,x0,2.
  - Required: x0=0, x6=0, x7=2.
- JALR/LUI:
  - Program: LUI x1,0x12345; AUIPC x2,0; JALR x3,13(x0).
  - Required: x1=0x12345000, x2=address of the AUIPC, x3=pc+4 of the JALR, next pc=12.
- Reset mid-run:
  - Stimulus: assert rst for 1 cycle after 3 instructions.
  - Required: pc=0 and all registers 0; dmem contents unchanged; execution restarts from 0.
